// File: rtl/bcd_display_scan.sv
// bcd_display_scan: scans an 8-digit BCD word onto a common-anode display, with tear-free frame-boundary updates
module bcd_display_scan #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [4*NUM_DIGITS-1:0] load_bcd_i,
  input  logic                    blank_lz_i,
  output logic [3:0]              digit_o,
  output logic [NUM_DIGITS-1:0]   anode_o,
  output logic [2:0]              digit_idx_o
);
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  logic [PW-1:0]           presc_q, presc_d;
  logic [2:0]              idx_q, idx_d, msd;
  logic [4*NUM_DIGITS-1:0] display_q, display_d, shadow_q, shadow_d, sel;
  logic                    pending_q, pending_d, tick, wrap, xfer, commit;
  logic [3:0]              digit_q, digit_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (display_q[4*i +: 4] != 4'd0) msd = 3'(i);
  end
  always_comb begin
    tick      = presc_q == PW'(REFRESH_DIV - 1);
    wrap      = tick && idx_q == 3'(NUM_DIGITS - 1);
    xfer      = load_valid_i && !pending_q;
    commit    = wrap && pending_q;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    idx_d     = wrap ? 3'd0 : tick ? idx_q + 3'd1 : idx_q;
    shadow_d  = xfer ? load_bcd_i : shadow_q;
    display_d = commit ? shadow_q : display_q;
    pending_d = xfer || (pending_q && !commit);
    sel       = display_q >> {idx_q, 2'b00};
    digit_d   = sel[3:0];
    // blanked digits keep driving the nibble but leave their anode off
    anode_d   = (blank_lz_i && idx_q > msd) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q   <= '0;
      idx_q     <= '0;
      display_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      digit_q   <= '0;
      anode_q   <= '1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      display_q <= display_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      digit_q   <= digit_d;
      anode_q   <= anode_d;
    end
  end
  assign load_ready_o = !pending_q;
  assign digit_o      = digit_q;
  assign anode_o      = anode_q;
  assign digit_idx_o  = idx_q;
endmodule
